// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset PC and queue entry type for the fetch stage.
package fetch_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;
  localparam logic [DATA_W-1:0] NOP_INSN = 32'h0;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] insn;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction queue with push/pop/flush; flush beats push.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic [$clog2(QDEPTH+1)-1:0]  count
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH+1);
  fetch_entry_t mem_q [QDEPTH];
  fetch_entry_t last_q, last_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH-1)) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    do_pop = pop & (cnt_q != '0);
    rd_d   = flush ? '0 : do_pop ? nxt(rd_q) : rd_q;
    wr_d   = flush ? '0 : push ? nxt(wr_q) : wr_q;
    cnt_d  = flush ? '0 : cnt_q + CW'(push) - CW'(do_pop);
    // an empty queue keeps showing the last head it presented
    head   = (cnt_q != '0) ? mem_q[rd_q] : last_q;
    last_d = head;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      last_q <= '{pc: '0, insn: NOP_INSN};
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push && !flush) mem_q[wr_q] <= push_data;
  end
  assign count = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, imem request credit logic and decode handshake.
// Optional FETCH_PERF_CNT_EN adds perf_fetched/perf_bubbles counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                             ADDR_W   = fetch_pkg::ADDR_W,
  parameter int                             DATA_W   = fetch_pkg::DATA_W,
  parameter logic [fetch_pkg::ADDR_W-1:0]   RESET_PC = fetch_pkg::RESET_PC,
  parameter int                             QDEPTH   = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_q,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_insn,
  output logic [ADDR_W-1:0] out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles
`endif
);
  localparam int CW = $clog2(QDEPTH+1);
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic req_v_q, req_v_d;
  logic [CW-1:0] cnt;
  logic [CW:0] occ;
  logic pop, push, issue;
  fetch_entry_t head;
  always_comb begin
    imem_addr  = redirect_valid ? redirect_pc : fetch_pc_q;
    out_valid  = cnt != '0;
    out_pc     = head.pc;
    out_insn   = head.insn;
    pop        = out_valid & out_ready;
    // occupancy counts the in-flight response so it always has a slot waiting
    occ        = {1'b0, cnt} + (CW+1)'(req_v_q) - (CW+1)'(pop);
    issue      = redirect_valid | (occ < (CW+1)'(QDEPTH));
    req_v_d    = issue;
    req_pc_d   = issue ? imem_addr : req_pc_q;
    fetch_pc_d = issue ? imem_addr + ADDR_W'(1) : fetch_pc_q;
    push       = req_v_q & ~redirect_valid;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      req_v_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      req_v_q    <= req_v_d;
    end
  end
  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ('{pc: req_pc_q, insn: imem_q}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (cnt)
  );
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d, bubbles_q, bubbles_d;
  always_comb begin
    fetched_d = fetched_q + 32'(pop);
    bubbles_d = bubbles_q + 32'(out_ready & ~out_valid);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      bubbles_q <= bubbles_d;
    end
  end
  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit (streaming, stall, redirect, wrap, reset).
module tb_fetch_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] imem_addr;
  logic [31:0] imem_q = '0;
  logic        redirect_valid = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_insn;
  logic [11:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif
  int vectors = 0;
  int miscompares = 0;
  int xfers = 0;
  logic [11:0] exp_q[$];

  always #5 clock = ~clock;
  always @(posedge clock) imem_q <= 32'h1000_0000 + {20'h0, imem_addr};

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_q         (imem_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_insn       (out_insn),
    .out_pc         (out_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [11:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 12'(i));
  endtask

  task automatic sample();
    logic [11:0] e;
    @(negedge clock);
    if (out_valid && out_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_pc", {20'h0, out_pc}, {20'h0, e});
        check("out_insn", out_insn, 32'h1000_0000 + {20'h0, e});
      end
      xfers++;
    end else if (out_valid && exp_q.size() != 0) begin
      check("stall_pc", {20'h0, out_pc}, {20'h0, exp_q[0]});
      check("stall_insn", out_insn, 32'h1000_0000 + {20'h0, exp_q[0]});
    end
    if (redirect_valid) load(redirect_pc);
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("rst_valid_async", {31'h0, out_valid}, 0);
    check("rst_imem_addr", {20'h0, imem_addr}, 0);
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_pc", {20'h0, out_pc}, 0);
    check("rst_out_insn", out_insn, 0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_fetched", perf_fetched, 0);
    check("rst_perf_bubbles", perf_bubbles, 0);
`endif
    reset = 1'b1;
    load(12'h000);
    xfers = 0;
  endtask

  initial begin
    do_reset();
    for (int c = 0; c < 16; c++) begin
      out_ready = !(c >= 4 && c <= 7);
      sample();
      if (c < 2) check("latency_valid", {31'h0, out_valid}, 0);
      if (c == 2) check("first_valid", {31'h0, out_valid}, 1);
      if (c >= 4 && c <= 7) check("stall_imem_addr", {20'h0, imem_addr}, 4);
      adv();
    end
    check("stream_xfers", xfers, 10);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, 10);
    check("perf_bubbles", perf_bubbles, 2);
`endif

    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      redirect_valid = (c == 6);
      redirect_pc = 12'h100;
      sample();
      if (c == 7) check("redir_bubble", {31'h0, out_valid}, 0);
      if (c == 8) check("redir_first_pc", {20'h0, out_pc}, 32'h100);
      adv();
    end
    redirect_valid = 1'b0;
    check("redir_xfers", xfers, 9);

    xfers = 0;
    for (int c = 0; c < 10; c++) begin
      redirect_valid = (c < 2);
      redirect_pc = (c == 0) ? 12'h200 : 12'hFFF;
      sample();
      if (c == 2) check("b2b_bubble", {31'h0, out_valid}, 0);
      if (c == 3) check("wrap_first_pc", {20'h0, out_pc}, 32'hFFF);
      adv();
    end
    redirect_valid = 1'b0;
    check("wrap_xfers", xfers, 8);

    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      sample();
      check("fill_valid", {31'h0, out_valid}, 1);
      adv();
    end
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      sample();
      adv();
    end
    check("restart_xfers", xfers, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
